// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single backing-memory line-fill port between the instruction
// cache miss path (fetch, "i") and the data cache miss path (load, "d").
// One fill is in flight at a time. Load normally wins. A streak counter
// limits how many consecutive unmerged load grants may pass a waiting
// fetch. When both caches miss on the same 4-word line, one memory
// transaction answers both of them.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   iReq / iAddr      fetch line-fill request (level) and word address
//   iReady / iData    one-cycle completion pulse and line returned to fetch
//   dReq / dAddr      load line-fill request (level) and word address
//   dReady / dData    one-cycle completion pulse and line returned to load
//   memReq / memAddr  memory transaction request (level), line-aligned address
//   memReady/memData  memory completion pulse and line from memory
//   busy              high whenever a transaction is in progress
//   owner             current grant: 0 = load, 1 = fetch (0 when idle)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 64,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch side
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iReady,
  output logic [DATA_W-1:0] iData,
  // load side
  input  logic              dReq,
  input  logic [ADDR_W-1:0] dAddr,
  output logic              dReady,
  output logic [DATA_W-1:0] dData,
  // memory side
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memReady,
  input  logic [DATA_W-1:0] memData,
  // status
  output logic              busy,
  output logic              owner
);

  localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_LOAD  = 1'b0,
    OWN_FETCH = 1'b1
  } owner_e;

  state_e              state_q,  state_d;
  owner_e              owner_q,  owner_d;
  logic                merge_q,  merge_d;
  logic [ADDR_W-3:0]   line_q,   line_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [DATA_W-1:0]   i_data_q, i_data_d;
  logic [DATA_W-1:0]   d_data_q, d_data_d;

  // Line number of each requester (word address without the word-in-line bits)
  logic [ADDR_W-3:0] i_line;
  logic [ADDR_W-3:0] d_line;
  logic              grant_fetch;
  logic              same_line;

  assign i_line = iAddr[ADDR_W-1:2];
  assign d_line = dAddr[ADDR_W-1:2];

  // The word-in-line bits never matter: the memory always moves a whole line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iAddr[1:0], dAddr[1:0]};

  // Fetch wins only when load is absent or load has used up its streak.
  assign grant_fetch = iReq && (!dReq || (streak_q == STREAK_MAX));
  assign same_line   = iReq && dReq && (i_line == d_line);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    owner_d  = owner_q;
    merge_d  = merge_q;
    line_d   = line_q;
    streak_d = streak_q;
    i_data_d = i_data_q;
    d_data_d = d_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (iReq || dReq) begin
          owner_d = grant_fetch ? OWN_FETCH : OWN_LOAD;
          line_d  = grant_fetch ? i_line : d_line;
          merge_d = same_line;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Requester addresses are deliberately not looked at here: the line
        // was latched at grant time and memAddr must stay stable.
        if (memReady) begin
          if (owner_q == OWN_FETCH || merge_q) i_data_d = memData;
          if (owner_q == OWN_LOAD  || merge_q) d_data_d = memData;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        // Only an unmerged load grant counts against a waiting fetch; any
        // grant that also served fetch clears the streak.
        if (owner_q == OWN_LOAD && !merge_q) begin
          streak_d = (streak_q == STREAK_MAX) ? streak_q
                                               : streak_q + STREAK_W'(1);
        end else begin
          streak_d = '0;
        end
        owner_d = OWN_LOAD;
        merge_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so that every
    // register samples the pre-edge values of the others.
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_LOAD;
      merge_q  <= 1'b0;
      line_q   <= '0;
      streak_q <= '0;
      // NOTE: the line data registers are reset too, so iData/dData read as
      // zero before the first fill instead of carrying X into the caches.
      i_data_q <= '0;
      d_data_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      merge_q  <= merge_d;
      line_q   <= line_d;
      streak_q <= streak_d;
      i_data_q <= i_data_d;
      d_data_q <= d_data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: all derived from registers, so they glitch-free follow the state
  // and memReq drops at once on an asynchronous reset.
  // -------------------------------------------------------------------------
  assign memReq  = (state_q == ST_WAIT);
  assign memAddr = {line_q, 2'b00};
  assign iReady  = (state_q == ST_RESP) && (owner_q == OWN_FETCH || merge_q);
  assign dReady  = (state_q == ST_RESP) && (owner_q == OWN_LOAD  || merge_q);
  assign iData   = i_data_q;
  assign dData   = d_data_q;
  assign busy    = (state_q != ST_IDLE);
  assign owner   = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. Directed scenario tasks cover
// reset, single fetch, load-before-fetch ordering, the fetch starvation
// guard, merged fills, reset during a fill and zero-wait memory. A final
// randomized run compares the DUT cycle by cycle against a transaction-level
// model of the arbitration rules.
// All stimulus is driven and all outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 64;
  localparam int MAX_DSTREAK = 4;

  logic              clk;
  logic              rst_n;
  logic              iReq,  dReq,  memReady;
  logic [ADDR_W-1:0] iAddr, dAddr, memAddr;
  logic              iReady, dReady, memReq, busy, owner;
  logic [DATA_W-1:0] iData, dData, memData;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_DSTREAK(MAX_DSTREAK)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iReq    (iReq),
    .iAddr   (iAddr),
    .iReady  (iReady),
    .iData   (iData),
    .dReq    (dReq),
    .dAddr   (dAddr),
    .dReady  (dReady),
    .dData   (dData),
    .memReq  (memReq),
    .memAddr (memAddr),
    .memReady(memReady),
    .memData (memData),
    .busy    (busy),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- memory responder (stepped from the test process) -------
  bit                mem_en;
  int                mem_lat;
  int                mem_cnt;
  logic [DATA_W-1:0] mem_last_data;

  // Decides memReady for the coming edge, from memReq seen this cycle.
  task automatic mem_step();
    if (mem_en) begin
      memReady = 1'b0;
      if (rst_n && memReq) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          memReady      = 1'b1;
          memData       = {$urandom(), $urandom()};
          mem_last_data = memData;
          mem_cnt       = 0;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  endtask

  task automatic step();
    mem_step();
    @(negedge clk);
  endtask

  // ---------------- observation window ----------------
  bit                g_owner_q[$];
  logic [ADDR_W-1:0] g_addr_q[$];
  int                w_memreq_cyc, w_i_cnt, w_d_cnt, w_i_at, w_d_at;
  logic [DATA_W-1:0] w_i_data, w_d_data, w_i_exp, w_d_exp;
  bit                w_prev_memreq;
  bit                i_reissue, d_reissue;

  task automatic clear_watch();
    g_owner_q.delete();
    g_addr_q.delete();
    w_memreq_cyc = 0; w_i_cnt = 0; w_d_cnt = 0; w_i_at = -1; w_d_at = -1;
    w_i_data = '0; w_d_data = '0; w_i_exp = '0; w_d_exp = '0;
    w_prev_memreq = memReq;
  endtask

  // Runs ncyc cycles, logging grants and ready pulses. A requester drops its
  // request on ready unless told to issue a fresh one straight away.
  task automatic watch(input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (memReq) w_memreq_cyc++;
      if (memReq && !w_prev_memreq) begin
        g_owner_q.push_back(owner);
        g_addr_q.push_back(memAddr);
      end
      w_prev_memreq = memReq;
      if (iReady) begin
        w_i_cnt++; w_i_at = c; w_i_data = iData; w_i_exp = mem_last_data;
        iReq = i_reissue;
      end
      if (dReady) begin
        w_d_cnt++; w_d_at = c; w_d_data = dData; w_d_exp = mem_last_data;
        dReq = d_reissue;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    iReq = 1'b0; dReq = 1'b0; iAddr = '0; dAddr = '0;
    memReady = 1'b0; memData = '0;
    mem_en = 1'b1; mem_lat = 1; mem_cnt = 0; mem_last_data = '0;
    i_reissue = 1'b0; d_reissue = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_watch();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mem_en = 1'b0;
    iReq = 1'b1; dReq = 1'b1; iAddr = 16'h1234; dAddr = 16'h4321;
    memReady = 1'b1; memData = '1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, owner, memReq, iReady, dReady} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", {busy, owner, memReq, iReady, dReady}, 5'b0);
    end
    checks++;
    if (memAddr !== 16'h0000) begin
      failures++; $display("FAIL reset_memAddr got=%h exp=0000", memAddr);
    end
    checks++;
    if (iData !== 64'd0 || dData !== 64'd0) begin
      failures++; $display("FAIL reset_data got i=%h d=%h exp 0", iData, dData);
    end
    // Requests pending across a clock edge must not start anything in reset.
    @(posedge clk); #1;
    checks++;
    if ({busy, memReq} !== 2'b00) begin
      failures++; $display("FAIL reset_hold got busy,memReq=%b exp=00", {busy, memReq});
    end
    do_reset();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_release got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    mem_lat = 3;
    iAddr = 16'h0047; iReq = 1'b1;
    watch(8);
    checks++;
    if (g_addr_q.size() != 1) begin
      failures++; $display("FAIL fetch_grants got=%0d exp=1", g_addr_q.size());
    end else begin
      checks++;
      if (g_addr_q[0] !== 16'h0044) begin
        failures++; $display("FAIL fetch_memAddr got=%h exp=0044", g_addr_q[0]);
      end
      checks++;
      if (g_owner_q[0] !== 1'b1) begin
        failures++; $display("FAIL fetch_owner got=%b exp=1", g_owner_q[0]);
      end
    end
    checks++;
    if (w_memreq_cyc != 3) begin
      failures++; $display("FAIL fetch_memReq_len got=%0d exp=3", w_memreq_cyc);
    end
    checks++;
    if (w_i_cnt != 1 || w_i_at != 4) begin
      failures++; $display("FAIL fetch_iReady got cnt=%0d at=%0d exp cnt=1 at=4", w_i_cnt, w_i_at);
    end
    checks++;
    if (w_i_data !== w_i_exp) begin
      failures++; $display("FAIL fetch_iData got=%h exp=%h", w_i_data, w_i_exp);
    end
    checks++;
    if (w_d_cnt != 0) begin
      failures++; $display("FAIL fetch_no_dReady got=%0d exp=0", w_d_cnt);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    mem_lat = 2;
    iAddr = 16'h0010; dAddr = 16'h0020;
    iReq = 1'b1; dReq = 1'b1;
    watch(12);
    checks++;
    if (g_addr_q.size() != 2) begin
      failures++; $display("FAIL simul_grants got=%0d exp=2", g_addr_q.size());
    end else begin
      checks++;
      if ({g_owner_q[0], g_addr_q[0]} !== {1'b0, 16'h0020}) begin
        failures++; $display("FAIL simul_first got own=%b addr=%h exp own=0 addr=0020", g_owner_q[0], g_addr_q[0]);
      end
      checks++;
      if ({g_owner_q[1], g_addr_q[1]} !== {1'b1, 16'h0010}) begin
        failures++; $display("FAIL simul_second got own=%b addr=%h exp own=1 addr=0010", g_owner_q[1], g_addr_q[1]);
      end
    end
    checks++;
    if (w_d_cnt != 1 || w_i_cnt != 1 || w_d_at >= w_i_at) begin
      failures++; $display("FAIL simul_ready_order got d@%0d i@%0d exp d before i", w_d_at, w_i_at);
    end
    checks++;
    if (w_i_data !== w_i_exp || w_d_data !== w_d_exp) begin
      failures++; $display("FAIL simul_data got i=%h d=%h exp i=%h d=%h", w_i_data, w_d_data, w_i_exp, w_d_exp);
    end
  endtask

  task automatic test_starvation();
    logic exp_own;
    do_reset();
    mem_lat = 1;
    i_reissue = 1'b1; d_reissue = 1'b1;
    iAddr = 16'h0030; dAddr = 16'h0040;
    iReq = 1'b1; dReq = 1'b1;
    watch(40);
    i_reissue = 1'b0; d_reissue = 1'b0;
    iReq = 1'b0; dReq = 1'b0;
    watch(4);
    checks++;
    if (g_owner_q.size() < 10) begin
      failures++; $display("FAIL starve_grants got=%0d exp>=10", g_owner_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        exp_own = ((k % 5) == 4);
        checks++;
        if (g_owner_q[k] !== exp_own || g_addr_q[k] !== (exp_own ? 16'h0030 : 16'h0040)) begin
          failures++;
          $display("FAIL starve_grant%0d got own=%b addr=%h exp own=%b", k, g_owner_q[k], g_addr_q[k], exp_own);
        end
      end
    end
  endtask

  task automatic test_merge();
    do_reset();
    mem_lat = 1;
    // Three lone loads build a streak of 3.
    for (int n = 0; n < 3; n++) begin
      dAddr = 16'h0050; dReq = 1'b1;
      watch(3);
    end
    clear_watch();
    mem_lat = 2;
    iAddr = 16'h0103; dAddr = 16'h0101;
    iReq = 1'b1; dReq = 1'b1;
    watch(5);
    checks++;
    if (g_addr_q.size() != 1 || g_addr_q[0] !== 16'h0100 || g_owner_q[0] !== 1'b0) begin
      failures++;
      $display("FAIL merge_txn got n=%0d addr=%h exp n=1 addr=0100 own=0", g_addr_q.size(),
               (g_addr_q.size() > 0) ? g_addr_q[0] : 16'hxxxx);
    end
    checks++;
    if (w_i_cnt != 1 || w_d_cnt != 1 || w_i_at != w_d_at) begin
      failures++; $display("FAIL merge_ready got i@%0d d@%0d exp same cycle", w_i_at, w_d_at);
    end
    checks++;
    if (w_i_data !== w_i_exp || w_d_data !== w_i_exp) begin
      failures++; $display("FAIL merge_data got i=%h d=%h exp=%h", w_i_data, w_d_data, w_i_exp);
    end
    // Streak must now be 0: four loads pass before fetch gets in.
    clear_watch();
    mem_lat = 1;
    i_reissue = 1'b1; d_reissue = 1'b1;
    iAddr = 16'h0060; dAddr = 16'h0070;
    iReq = 1'b1; dReq = 1'b1;
    watch(17);
    i_reissue = 1'b0; d_reissue = 1'b0;
    iReq = 1'b0; dReq = 1'b0;
    watch(4);
    checks++;
    if (g_owner_q.size() < 5) begin
      failures++; $display("FAIL merge_streak_grants got=%0d exp>=5", g_owner_q.size());
    end else begin
      checks++;
      if ({g_owner_q[0], g_owner_q[1], g_owner_q[2], g_owner_q[3], g_owner_q[4]} !== 5'b00001) begin
        failures++;
        $display("FAIL merge_streak got=%b exp=00001",
                 {g_owner_q[0], g_owner_q[1], g_owner_q[2], g_owner_q[3], g_owner_q[4]});
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit bad;
    do_reset();
    mem_en = 1'b0;
    iAddr = 16'h0077; iReq = 1'b1;
    step();
    step();
    checks++;
    if (memReq !== 1'b1) begin
      failures++; $display("FAIL rstwait_pre got memReq=%b exp=1", memReq);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({memReq, busy, iReady, dReady, owner} !== 5'b0) begin
      failures++;
      $display("FAIL rstwait_async got=%b exp=00000", {memReq, busy, iReady, dReady, owner});
    end
    iReq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    memReady = 1'b1; memData = {$urandom(), $urandom()};
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      memReady = 1'b0;
      if (iReady || dReady || busy || memReq) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0 || iData !== 64'd0) begin
      failures++; $display("FAIL rstwait_late_mem got activity=%b iData=%h exp none, 0", bad, iData);
    end
  endtask

  task automatic test_zero_wait();
    logic [DATA_W-1:0] hold_i, hold_d;
    bit bad;
    do_reset();
    mem_lat = 1;
    dAddr = 16'h0085; dReq = 1'b1;
    watch(3);
    checks++;
    if (w_d_cnt != 1 || w_d_at != 2 || w_memreq_cyc != 1) begin
      failures++;
      $display("FAIL zw_latency got ready@%0d memReq_cyc=%0d exp ready@2 memReq_cyc=1", w_d_at, w_memreq_cyc);
    end
    checks++;
    if (w_d_data !== w_d_exp || g_addr_q.size() != 1 || g_addr_q[0] !== 16'h0084) begin
      failures++; $display("FAIL zw_data got d=%h exp=%h", w_d_data, w_d_exp);
    end
    // Spurious memory pulse while idle.
    mem_en = 1'b0;
    hold_i = iData; hold_d = dData;
    memReady = 1'b1; memData = ~dData;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      memReady = 1'b0;
      if (iReady || dReady || busy || memReq || iData !== hold_i || dData !== hold_d) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++; $display("FAIL zw_spurious got output change=%b exp=0", bad);
    end
  endtask

  // ---------------- randomized run against a transaction model -------------
  task automatic test_random(input int ncyc);
    int                streak;
    bit                open, resp_due, can_grant, win_fetch, merge, exp_ir, exp_dr;
    bit                pi, pd;
    logic [ADDR_W-1:0] pia, pda, exp_addr;
    logic [DATA_W-1:0] exp_data, last_i, last_d;
    logic [4:0]        exp_vec, obs_vec;

    do_reset();
    mem_en = 1'b0;
    streak = 0; open = 0; resp_due = 0; can_grant = 1; win_fetch = 0; merge = 0;
    pi = 0; pd = 0; pia = '0; pda = '0; exp_addr = '0; exp_data = '0;
    last_i = '0; last_d = '0;

    for (int c = 0; c < ncyc; c++) begin
      // Expected outputs for this cycle.
      if (resp_due) begin
        exp_ir  = win_fetch || merge;
        exp_dr  = !win_fetch || merge;
        exp_vec = {1'b1, 1'b0, win_fetch, exp_ir, exp_dr};
        if (exp_ir) last_i = exp_data;
        if (exp_dr) last_d = exp_data;
        if (!win_fetch && !merge) streak = (streak < MAX_DSTREAK) ? streak + 1 : MAX_DSTREAK;
        else                      streak = 0;
        open = 0; resp_due = 0; can_grant = 0;
      end else begin
        if (!open && can_grant && (pi || pd)) begin
          win_fetch = pi && (!pd || streak == MAX_DSTREAK);
          merge     = pi && pd && (pia[ADDR_W-1:2] == pda[ADDR_W-1:2]);
          exp_addr  = win_fetch ? {pia[ADDR_W-1:2], 2'b00} : {pda[ADDR_W-1:2], 2'b00};
          open      = 1;
        end
        exp_vec   = open ? {1'b1, 1'b1, win_fetch, 1'b0, 1'b0} : 5'b0;
        can_grant = !open;
      end

      obs_vec = {busy, memReq, owner, iReady, dReady};
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL rnd_ctrl cyc=%0d got busy,memReq,owner,iRdy,dRdy=%b exp=%b", c, obs_vec, exp_vec);
      end
      if (exp_vec[3]) begin
        checks++;
        if (memAddr !== exp_addr) begin
          failures++; $display("FAIL rnd_memAddr cyc=%0d got=%h exp=%h", c, memAddr, exp_addr);
        end
      end
      checks++;
      if (iData !== last_i || dData !== last_d) begin
        failures++;
        $display("FAIL rnd_data cyc=%0d got i=%h d=%h exp i=%h d=%h", c, iData, dData, last_i, last_d);
      end

      // Requester agents.
      if (iReady) pi = 0;
      else if (!pi) begin
        if ($urandom_range(0, 2) == 0) begin pi = 1; pia = 16'h0200 + ADDR_W'($urandom_range(0, 15)); end
      end else if ($urandom_range(0, 7) == 0) pia = 16'h0200 + ADDR_W'($urandom_range(0, 15));
      if (dReady) pd = 0;
      else if (!pd) begin
        if ($urandom_range(0, 2) == 0) begin pd = 1; pda = 16'h0200 + ADDR_W'($urandom_range(0, 15)); end
      end else if ($urandom_range(0, 7) == 0) pda = 16'h0200 + ADDR_W'($urandom_range(0, 15));
      iReq = pi; iAddr = pia;
      dReq = pd; dAddr = pda;

      // Memory: random latency while waiting, stray pulses otherwise.
      memReady = ($urandom_range(0, 2) == 0);
      memData  = {$urandom(), $urandom()};
      resp_due = open && memReady;
      if (resp_due) exp_data = memData;

      @(negedge clk);
    end
    memReady = 1'b0; iReq = 1'b0; dReq = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    iReq = 1'b0; dReq = 1'b0; iAddr = '0; dAddr = '0;
    memReady = 1'b0; memData = '0;
    mem_en = 1'b0; mem_lat = 1; mem_cnt = 0; mem_last_data = '0;
    i_reissue = 1'b0; d_reissue = 1'b0;

    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_merge();
    test_reset_mid_wait();
    test_zero_wait();
    test_random(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
